// File: rtl/spi_frame_controller_if.sv
// Command/error bus of the SPI frame controller: the controller is the master,
// the downstream consumer is the slave and owns cmd_ready.
interface spi_frame_controller_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode;
    logic [5:0]  cmd_addr;
    logic [23:0] cmd_data;
    logic        err_valid;
    logic [2:0]  err_code;

    modport master (
        output cmd_valid, cmd_opcode, cmd_addr, cmd_data, err_valid, err_code,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_addr, cmd_data, err_valid, err_code,
        output cmd_ready
    );
endinterface

// File: rtl/spi_frame_controller.sv
// Samples a raw SPI slave port, validates 32-bit command frames and issues one
// command at a time over a valid/ready handshake, reporting rejected frames.
module spi_frame_controller #(
    parameter int NUM_CHANNELS   = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sclk,
    input  logic                          ss_n,
    input  logic                          mosi,
    spi_frame_controller_if.master        cmd_bus,
    output logic [15:0]                   frame_count,
    output logic                          busy
);
    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]        CHAN_LIMIT = 7'(NUM_CHANNELS);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ISSUE, DRAIN} state_t;

    logic [2:0]        sclk_sync_reg, ss_sync_reg, mosi_sync_reg;
    state_t            state_reg;
    logic [31:0]       shift_reg;
    logic [5:0]        bit_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              overrun_reg, drain_err_reg;
    logic [1:0]        settle_reg;
    logic              armed_reg;
    logic              cmd_valid_reg, err_valid_reg, busy_reg;
    logic [1:0]        opcode_reg;
    logic [5:0]        addr_reg;
    logic [23:0]       data_reg;
    logic [2:0]        err_code_reg, check_code;
    logic [15:0]       frame_count_reg;
    logic              sclk_rise, ss_fall, ss_rise, issue_overrun;

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_reg <= 3'b000;
            ss_sync_reg   <= 3'b111;
            mosi_sync_reg <= 3'b000;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
            ss_sync_reg   <= {ss_sync_reg[1:0], ss_n};
            mosi_sync_reg <= {mosi_sync_reg[1:0], mosi};
        end
    end

    assign sclk_rise     = ~sclk_sync_reg[2] & sclk_sync_reg[1];
    assign ss_fall       = ss_sync_reg[2] & ~ss_sync_reg[1];
    assign ss_rise       = ~ss_sync_reg[2] & ss_sync_reg[1];
    assign issue_overrun = overrun_reg | ss_fall;

    // Frame validation, highest-priority failure wins.
    always_comb begin
        check_code = 3'b000;
        if (bit_cnt_reg != 6'd32)
            check_code = 3'b001;
        else if (shift_reg[31:30] == 2'b00 || shift_reg[31:30] == 2'b11)
            check_code = 3'b010;
        else if ({1'b0, shift_reg[29:24]} >= CHAN_LIMIT)
            check_code = 3'b011;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            wait_cnt_reg    <= '0;
            overrun_reg     <= 1'b0;
            drain_err_reg   <= 1'b0;
            settle_reg      <= '0;
            armed_reg       <= 1'b0;
            cmd_valid_reg   <= 1'b0;
            err_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            opcode_reg      <= '0;
            addr_reg        <= '0;
            data_reg        <= '0;
            err_code_reg    <= '0;
            frame_count_reg <= '0;
        end else begin
            err_valid_reg <= 1'b0;
            // A frame already running at reset release must not be picked up
            // mid-way: only arm once the flushed synchronizer shows ss_n idle.
            if (settle_reg != 2'd3)
                settle_reg <= settle_reg + 2'd1;
            else if (ss_sync_reg[2] & ss_sync_reg[1])
                armed_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (ss_fall && armed_reg) begin
                        state_reg   <= SHIFT;
                        shift_reg   <= '0;
                        bit_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Stage 2 of mosi is the value held just before the decoded sclk rise.
                    if (sclk_rise) begin
                        shift_reg <= {shift_reg[30:0], mosi_sync_reg[2]};
                        if (bit_cnt_reg != 6'd33)
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                    end
                    if (ss_rise)
                        state_reg <= CHECK;
                end
                CHECK: begin
                    if (check_code != 3'b000) begin
                        err_valid_reg <= 1'b1;
                        err_code_reg  <= check_code;
                        overrun_reg   <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else begin
                        cmd_valid_reg <= 1'b1;
                        opcode_reg    <= shift_reg[31:30];
                        addr_reg      <= shift_reg[29:24];
                        data_reg      <= shift_reg[23:0];
                        wait_cnt_reg  <= '0;
                        overrun_reg   <= ss_fall;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_bus.cmd_ready || wait_cnt_reg == WAIT_LAST) begin
                        cmd_valid_reg <= 1'b0;
                        opcode_reg    <= '0;
                        addr_reg      <= '0;
                        data_reg      <= '0;
                        overrun_reg   <= 1'b0;
                        err_valid_reg <= issue_overrun | ~cmd_bus.cmd_ready;
                        if (cmd_bus.cmd_ready) begin
                            frame_count_reg <= frame_count_reg + 16'd1;
                            err_code_reg    <= issue_overrun ? 3'b100 : err_code_reg;
                        end else begin
                            // Timeout reported now; a pending overrun follows from DRAIN.
                            err_code_reg  <= 3'b101;
                            drain_err_reg <= issue_overrun;
                        end
                        if (issue_overrun) begin
                            state_reg <= DRAIN;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        overrun_reg  <= issue_overrun;
                    end
                end
                DRAIN: begin
                    if (drain_err_reg) begin
                        err_valid_reg <= 1'b1;
                        err_code_reg  <= 3'b100;
                        drain_err_reg <= 1'b0;
                    end
                    if (ss_sync_reg[1]) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_bus.cmd_valid  = cmd_valid_reg;
    assign cmd_bus.cmd_opcode = opcode_reg;
    assign cmd_bus.cmd_addr   = addr_reg;
    assign cmd_bus.cmd_data   = data_reg;
    assign cmd_bus.err_valid  = err_valid_reg;
    assign cmd_bus.err_code   = err_code_reg;
    assign frame_count        = frame_count_reg;
    assign busy               = busy_reg;
endmodule

// File: tb/tb_spi_frame_controller.sv
// Bench for spi_frame_controller: directed frames plus randomized frames checked
// against an event-queue reference model of the frame rules.
module tb_spi_frame_controller;
    localparam int HALF = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sclk  = 1'b0;
    logic        ss_n  = 1'b1;
    logic        mosi  = 1'b0;
    logic [15:0] frame_count;
    logic        busy;

    spi_frame_controller_if bus();

    spi_frame_controller #(.NUM_CHANNELS(8), .TIMEOUT_CYCLES(255)) dut (
        .clock       (clock),
        .reset       (reset),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .cmd_bus     (bus),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        bit          is_cmd;
        logic [2:0]  code;
        logic [31:0] word;
    } ev_t;

    ev_t         exp_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          unexpected_cnt = 0;
    bit          mon_en = 1'b0;
    int          ready_mode = 2;   // 0 random, 1 held low, 2 held high
    logic [15:0] model_count = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: outcome of one frame from its bit count and final 32-bit word.
    function automatic ev_t predict(input logic [63:0] bits, input int len);
        ev_t e;
        logic [31:0] w;
        w = bits[31:0];
        e.is_cmd = 1'b0;
        e.word   = w;
        if (len != 32)                              e.code = 3'd1;
        else if (w[31:30] == 2'b00 || w[31:30] == 2'b11) e.code = 3'd2;
        else if (w[29:24] >= 6'd8)                  e.code = 3'd3;
        else begin e.is_cmd = 1'b1; e.code = 3'd0; end
        return e;
    endfunction

    function automatic ev_t mk_err(input logic [2:0] code);
        ev_t e;
        e.is_cmd = 1'b0;
        e.code   = code;
        e.word   = 32'd0;
        return e;
    endfunction

    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       bus.cmd_ready = 1'($urandom_range(0, 1));
            1:       bus.cmd_ready = 1'b0;
            default: bus.cmd_ready = 1'b1;
        endcase
    end

    // Monitor: every handshake and every error pulse consumes one expected event.
    always @(negedge clock) begin
        ev_t e;
        if (mon_en && !reset) begin
            if (!bus.cmd_valid)
                check_eq("cmd_zero_when_idle", {bus.cmd_opcode, bus.cmd_addr, bus.cmd_data}, 32'd0);
            if (bus.cmd_valid && bus.cmd_ready) begin
                $display("cmd  op=%0d addr=%0d data=%06h", bus.cmd_opcode, bus.cmd_addr, bus.cmd_data);
                if (exp_q.size() == 0) begin
                    unexpected_cnt++;
                end else begin
                    e = exp_q.pop_front();
                    check_eq("event_kind_cmd", 32'd1, 32'(e.is_cmd));
                    check_eq("cmd_word", {bus.cmd_opcode, bus.cmd_addr, bus.cmd_data}, e.word);
                end
            end
            if (bus.err_valid) begin
                $display("err  code=%0d", bus.err_code);
                if (exp_q.size() == 0) begin
                    unexpected_cnt++;
                end else begin
                    e = exp_q.pop_front();
                    check_eq("event_kind_err", 32'd0, 32'(e.is_cmd));
                    check_eq("err_code", 32'(bus.err_code), 32'(e.code));
                end
            end
        end
    end

    task automatic ss_low();
        @(negedge clock);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic shift_bits(input logic [63:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            mosi = bits[i];
            repeat (HALF) @(negedge clock);
            sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    task automatic ss_high();
        repeat (HALF) @(negedge clock);
        ss_n = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] bits, input int len);
        ss_low();
        if (len > 0) shift_bits(bits, len - 1, 0);
        ss_high();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (2) @(negedge clock);
        while (busy && n < 2000) begin @(negedge clock); n++; end
        check_eq(tag, 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.cmd_valid && n < 60) begin @(negedge clock); n++; end
        check_eq(tag, 32'(bus.cmd_valid), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits;
        logic [63:0] dir_bits [4];
        int          dir_len  [4];
        ev_t         e;
        int          k, len, r;

        // Reset state
        repeat (4) @(negedge clock);
        check_eq("rst_cmd_valid",   32'(bus.cmd_valid),   32'd0);
        check_eq("rst_err_valid",   32'(bus.err_valid),   32'd0);
        check_eq("rst_err_code",    32'(bus.err_code),    32'd0);
        check_eq("rst_busy",        32'(busy),            32'd0);
        check_eq("rst_frame_count", 32'(frame_count),     32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (10) @(negedge clock);

        // Reset in the middle of a frame: that frame must never be captured
        bits = 64'h0000_0000_4312_3456;
        ss_low();
        shift_bits(bits, 31, 22);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("busy_after_midframe_reset", 32'(busy), 32'd0);
        shift_bits(bits, 21, 0);
        ss_high();
        repeat (12) @(negedge clock);
        check_eq("busy_after_lost_frame", 32'(busy), 32'd0);
        check_eq("count_after_lost_frame", 32'(frame_count), 32'd0);

        // Basic valid frame, latency and single-cycle valid
        ready_mode = 2;
        exp_q.push_back(predict(bits, 32));
        model_count++;
        ss_low();
        shift_bits(bits, 31, 0);
        ss_high();
        k = 0;
        do begin @(negedge clock); k++; end while (!bus.cmd_valid && k < 20);
        check_eq("issue_latency", 32'(k), 32'd4);
        @(negedge clock);
        check_eq("valid_one_cycle", 32'(bus.cmd_valid), 32'd0);
        wait_idle("idle_after_first");
        check_eq("count_first", 32'(frame_count), 32'(model_count));

        // Rejected frames
        dir_bits[0] = 64'h0000_0000_2189_1A2B; dir_len[0] = 31;
        dir_bits[1] = 64'h0000_00AB_4312_3456; dir_len[1] = 40;
        dir_bits[2] = 64'h0000_0000_4A00_0000; dir_len[2] = 32;
        dir_bits[3] = 64'h0000_0000_C000_0000; dir_len[3] = 32;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(predict(dir_bits[i], dir_len[i]));
            send_frame(dir_bits[i], dir_len[i]);
            wait_idle("idle_after_reject");
            check_eq("count_after_reject", 32'(frame_count), 32'(model_count));
        end

        // Timeout with cmd_ready held low
        ready_mode = 1;
        bits = 64'h0000_0000_8507_0FED;
        exp_q.push_back(mk_err(3'd5));
        send_frame(bits, 32);
        wait_valid("timeout_valid_seen");
        k = 0;
        while (bus.cmd_valid && k < 400) begin k++; @(negedge clock); end
        check_eq("timeout_valid_cycles", 32'(k), 32'd255);
        wait_idle("idle_after_timeout");
        check_eq("count_after_timeout", 32'(frame_count), 32'(model_count));

        // Overrun: second frame starts during ISSUE, ready raised mid-frame
        bits = 64'h0000_0000_4201_ABCD;
        e = predict(bits, 32);
        exp_q.push_back(e);
        exp_q.push_back(mk_err(3'd4));
        model_count++;
        send_frame(bits, 32);
        wait_valid("overrun_valid_seen");
        bits = 64'h0000_0000_4599_9999;
        ss_low();
        shift_bits(bits, 31, 24);
        ready_mode = 2;
        shift_bits(bits, 23, 0);
        ss_high();
        wait_idle("idle_after_overrun");
        check_eq("count_after_overrun", 32'(frame_count), 32'(model_count));

        // Timeout and overrun together: 101 then 100
        ready_mode = 1;
        bits = 64'h0000_0000_8611_2233;
        exp_q.push_back(mk_err(3'd5));
        exp_q.push_back(mk_err(3'd4));
        send_frame(bits, 32);
        wait_valid("tmo_ovr_valid_seen");
        send_frame(64'h0000_0000_4777_7777, 32);
        wait_idle("idle_after_tmo_ovr");
        check_eq("count_after_tmo_ovr", 32'(frame_count), 32'(model_count));

        // Counter wrap
        ready_mode = 2;
        @(negedge clock);
        force dut.frame_count_reg = 16'hFFFF;
        @(negedge clock);
        release dut.frame_count_reg;
        model_count = 16'hFFFF;
        @(negedge clock);
        check_eq("count_preset", 32'(frame_count), 32'(model_count));
        bits = 64'h0000_0000_4500_0001;
        exp_q.push_back(predict(bits, 32));
        model_count++;
        send_frame(bits, 32);
        wait_idle("idle_after_wrap");
        check_eq("count_wrap", 32'(frame_count), 32'(model_count));

        // Randomized frames with random cmd_ready
        ready_mode = 0;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       len = 32;
            else if (r == 6) len = 31;
            else if (r == 7) len = 33;
            else if (r == 8) len = 40;
            else             len = $urandom_range(0, 30);
            bits = {$urandom, $urandom};
            bits[29:24] = 6'($urandom_range(0, 11));
            e = predict(bits, len);
            exp_q.push_back(e);
            if (e.is_cmd) model_count++;
            send_frame(bits, len);
            wait_idle("idle_random");
            check_eq("count_random", 32'(frame_count), 32'(model_count));
        end

        repeat (5) @(negedge clock);
        check_eq("unexpected_events", 32'(unexpected_cnt), 32'd0);
        check_eq("missing_events", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
